// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared types and sizing helpers for the sequential binary-to-BCD converter
package bin2bcd_seq_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Converter control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Smallest digit count d such that 10^d > 2^width, i.e. enough digits
  // to hold any unsigned value of the given width.
  function automatic int min_digits(input int width);
    longint unsigned limit;
    longint unsigned pow;
    int              d;
    limit = 64'd1 << width;
    pow   = 64'd1;
    d     = 0;
    while (pow <= limit) begin
      pow = pow * 64'd10;
      d   = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// rtl/bin2bcd_seq_digit_adj.sv - double-dabble digit correction (+3 when digit >= 5)
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // A digit of 5..9 would overflow past 9 when doubled; pre-adding 3 makes
  // the subsequent left shift carry into the next digit correctly.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter with valid/ready handshakes
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      binary,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  // Parameter sanity: refuse to build a converter that cannot hold its range.
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH must be in 2..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH (10^DIGITS <= 2^WIDTH)");
  end

  state_t                 state;
  logic [CW-1:0]          count;
  logic [4*DIGITS-1:0]    digits;
  logic [4*DIGITS-1:0]    adj;
  logic [WIDTH-1:0]       mag;
  logic                   sign_q;
  logic                   is_neg;
  logic [WIDTH-1:0]       accept_mag;

  // One correction cell per digit, applied to the current digit register
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (digits[4*i +: 4]),
      .adjusted (adj[4*i +: 4])
    );
  end

  // Magnitude and sign of the incoming request; most-negative value negates
  // to 2^(WIDTH-1), which still fits WIDTH bits when read as unsigned.
  always_comb begin
    is_neg     = signed_mode & binary[WIDTH-1];
    accept_mag = binary;
    if (is_neg) begin
      accept_mag = ~binary + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Control FSM plus the combined digits||magnitude shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      digits <= '0;
      sign_q <= 1'b0;
      mag    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mag    <= accept_mag;
            sign_q <= is_neg;
            digits <= '0;
            count  <= CW'(WIDTH);
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          digits <= {adj[4*DIGITS-2:0], mag[WIDTH-1]};
          mag    <= {mag[WIDTH-2:0], 1'b0};
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode straight from state; results hold until next accept
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    bcd       = digits;
    sign      = sign_q;
  end

endmodule
